// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store.
// LS has priority; handles RV32I sub-word lanes, faults and a memory watchdog.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [2:0]  ls_funct3,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_valid,
  output logic        ls_fault,
  output logic        ls_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LSU, DONE} state_t;
  state_t state, state_nx;

  logic [WD_W-1:0] wd_cnt;
  logic [2:0]      lat_f3;
  logic [1:0]      lat_off;
  logic            ls_legal, ls_misal, ls_bad, tmo;
  logic [3:0]      st_be;
  logic [31:0]     st_wdata, ld_shift, ld_ext;

  assign if_stall = if_req & ~if_valid;
  assign ls_stall = ls_req & ~ls_valid;

  always_comb begin
    ls_legal = 1'b0;
    case (ls_funct3)
      3'b000, 3'b001, 3'b010: ls_legal = 1'b1;
      3'b100, 3'b101:         ls_legal = ~ls_we;
      default:                ls_legal = 1'b0;
    endcase
    ls_misal = ((ls_funct3[1:0] == 2'b01) && ls_addr[0]) ||
               ((ls_funct3[1:0] == 2'b10) && (ls_addr[1:0] != 2'b00));
    ls_bad   = ~ls_legal | ls_misal;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ls_wdata;
    case (ls_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << ls_addr[1:0];
        st_wdata = {4{ls_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << ls_addr[1:0];
        st_wdata = {2{ls_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selected by the latched offset is shifted down before extension.
  always_comb begin
    ld_shift = mem_rdata >> {lat_off, 3'b000};
    case (lat_f3)
      3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
      3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  assign tmo = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (ls_req)      state_nx = ls_bad ? DONE : LSU;
                  else if (if_req) state_nx = FETCH;
      FETCH, LSU: if (mem_ack || tmo) state_nx = DONE;
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      if_valid  <= 1'b0;
      ls_valid  <= 1'b0;
      ls_fault  <= 1'b0;
      wd_cnt    <= '0;
      lat_f3    <= '0;
      lat_off   <= '0;
    end else begin
      if_valid <= 1'b0;
      ls_valid <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt   <= '0;
          ls_fault <= 1'b0;
          if (ls_req) begin
            lat_f3  <= ls_funct3;
            lat_off <= ls_addr[1:0];
            if (ls_bad) begin
              ls_fault <= 1'b1;
              ls_valid <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= ls_we;
              mem_addr  <= {ls_addr[31:2], 2'b00};
              mem_be    <= ls_we ? st_be : 4'b1111;
              mem_wdata <= ls_we ? st_wdata : 32'd0;
            end
          end else if (if_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[31:2], 2'b00};
            mem_be    <= 4'b1111;
            mem_wdata <= 32'd0;
          end
        end
        FETCH: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
          end else if (tmo) begin
            mem_req  <= 1'b0;
            if_rdata <= 32'h0000_0013;
            if_valid <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        LSU: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if (!mem_we) ls_rdata <= ld_ext;
            ls_valid <= 1'b1;
          end else if (tmo) begin
            mem_req  <= 1'b0;
            ls_rdata <= '0;
            ls_fault <= 1'b1;
            ls_valid <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        DONE:    ls_fault <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory model and a
// scoreboard of expected completions.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_valid, ls_fault, ls_stall;
  logic [2:0]  ls_funct3;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .ls_req(ls_req), .ls_we(ls_we), .ls_funct3(ls_funct3), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_valid(ls_valid),
    .ls_fault(ls_fault), .ls_stall(ls_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // Memory model: word-addressed, acks in the first mem_req cycle when enabled.
  logic        ack_en, force_ack;
  logic [31:0] mem [logic [31:0]];
  assign mem_ack = (mem_req & ack_en) | force_ack;
  always @(negedge clk) mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'hDEAD_BEEF;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
    bit          chk_rdata;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int reqc, waits;
  bit got_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_be;
  logic        s_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_addr = mem_addr; s_wdata = mem_wdata; s_be = mem_be; s_we = mem_we;
  endtask

  task automatic ls_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rd,
                           input logic exp_fault, input bit chk_rd,
                           input int exp_waits, input int exp_reqc, input string tag);
    exp_t e;
    logic [31:0] w;
    e.tag = tag; e.rdata = exp_rd; e.fault = exp_fault; e.chk_rdata = chk_rd;
    sb.push_back(e);
    @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata;
    reqc = 0; waits = 0; got_valid = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      waits++;
      if (mem_req) begin
        if (reqc == 0) snap();
        reqc++;
      end
      if (ls_valid) begin got_valid = 1; break; end
    end
    ls_req = 1'b0;
    e = sb.pop_front();
    chk({e.tag, " ls_valid"}, 32'(got_valid), 32'd1);
    if (got_valid) begin
      chk({e.tag, " ls_fault"}, 32'(ls_fault), 32'(e.fault));
      if (e.chk_rdata) chk({e.tag, " ls_rdata"}, ls_rdata, e.rdata);
      chk({e.tag, " latency"}, 32'(waits), 32'(exp_waits));
      chk({e.tag, " mem_req cycles"}, 32'(reqc), 32'(exp_reqc));
    end
    if (reqc > 0) chk({e.tag, " mem_addr"}, s_addr, {addr[31:2], 2'b00});
    if (we && reqc > 0 && ack_en) begin
      w = mem.exists(s_addr) ? mem[s_addr] : 32'd0;
      for (int b = 0; b < 4; b++) if (s_be[b]) w[8*b +: 8] = s_wdata[8*b +: 8];
      mem[s_addr] = w;
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_rd,
                       input int exp_waits, input int exp_reqc, input string tag);
    exp_t e;
    e.tag = tag; e.rdata = exp_rd; e.fault = 1'b0; e.chk_rdata = 1;
    sb.push_back(e);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    reqc = 0; waits = 0; got_valid = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      waits++;
      if (mem_req) begin
        if (reqc == 0) snap();
        reqc++;
      end
      if (if_valid) begin got_valid = 1; break; end
    end
    if_req = 1'b0;
    e = sb.pop_front();
    chk({e.tag, " if_valid"}, 32'(got_valid), 32'd1);
    if (got_valid) begin
      chk({e.tag, " if_rdata"}, if_rdata, e.rdata);
      chk({e.tag, " latency"}, 32'(waits), 32'(exp_waits));
      chk({e.tag, " mem_req cycles"}, 32'(reqc), 32'(exp_reqc));
    end
    if (reqc > 0) chk({e.tag, " fetch port"}, {s_addr[31:2], s_be, s_we},
                      {addr[31:2], 4'b1111, 1'b0});
  endtask

  initial begin
    int ls_t, if_t;
    bit stall_ok, ls_seen, if_seen;
    rst = 1'b1; force_ack = 1'b1; ack_en = 1'b1;
    if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_funct3 = 0; ls_addr = 0; ls_wdata = 0;
    mem[32'h0000_2000] = 32'h80FF_7F01;
    mem[32'h0000_1000] = 32'h1122_3344;
    mem[32'h0000_0100] = 32'h0050_0093;

    // Reset with mem_ack held high
    repeat (3) @(negedge clk);
    chk("rst mem_req",   32'(mem_req), 0);
    chk("rst mem_we",    32'(mem_we), 0);
    chk("rst mem_addr",  mem_addr, 0);
    chk("rst mem_be",    32'(mem_be), 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst if_rdata",  if_rdata, 0);
    chk("rst ls_rdata",  ls_rdata, 0);
    chk("rst valids",    {30'd0, if_valid, ls_valid}, 0);
    chk("rst ls_fault",  32'(ls_fault), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle no activity", {29'd0, mem_req, if_valid, ls_valid}, 0);
    end
    force_ack = 1'b0;

    // Simultaneous requests: LS first, fetch follows
    sb.push_back('{"prio ls", 32'h80FF_7F01, 1'b0, 1'b1});
    sb.push_back('{"prio if", 32'h0050_0093, 1'b0, 1'b1});
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    ls_req = 1; ls_we = 0; ls_funct3 = 3'b010; ls_addr = 32'h2000;
    ls_t = -1; if_t = -1; stall_ok = 1; ls_seen = 0; if_seen = 0;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      if (!if_seen && !if_valid && !if_stall) stall_ok = 0;
      if (ls_valid && !ls_seen) begin
        exp_t e;
        e = sb.pop_front();
        ls_seen = 1; ls_t = i; ls_req = 0;
        chk({e.tag, " rdata"}, ls_rdata, e.rdata);
        chk({e.tag, " if not yet"}, 32'(if_valid), 0);
      end
      if (if_valid) begin
        exp_t e;
        e = sb.pop_front();
        if_seen = 1; if_t = i; if_req = 0;
        chk({e.tag, " ls done first"}, 32'(ls_seen), 1);
        chk({e.tag, " rdata"}, if_rdata, e.rdata);
        break;
      end
    end
    chk("prio both done", {30'd0, ls_seen, if_seen}, 32'd3);
    chk("prio if_stall held", 32'(stall_ok), 1);
    chk("prio gap>=3", 32'(if_t - ls_t >= 3), 1);

    // Stores with lane replication
    ls_access(1, 3'b000, 32'h1003, 32'h0000_00AB, 0, 0, 0, 2, 1, "SB");
    chk("SB mem_be", 32'(s_be), 32'b1000);
    chk("SB mem_wdata", s_wdata, 32'hABAB_ABAB);
    chk("SB mem_we", 32'(s_we), 1);
    ls_access(0, 3'b010, 32'h1000, 0, 32'hAB22_3344, 0, 1, 2, 1, "LW after SB");
    ls_access(1, 3'b001, 32'h1000, 32'h1234_5566, 0, 0, 0, 2, 1, "SH");
    chk("SH mem_be", 32'(s_be), 32'b0011);
    chk("SH mem_wdata", s_wdata, 32'h5566_5566);
    ls_access(0, 3'b010, 32'h1000, 0, 32'hAB22_5566, 0, 1, 2, 1, "LW after SH");

    // Sub-word loads with extension
    ls_access(0, 3'b000, 32'h2001, 0, 32'h0000_007F, 0, 1, 2, 1, "LB 2001");
    ls_access(0, 3'b000, 32'h2002, 0, 32'hFFFF_FFFF, 0, 1, 2, 1, "LB 2002");
    ls_access(0, 3'b101, 32'h2002, 0, 32'h0000_80FF, 0, 1, 2, 1, "LHU 2002");
    ls_access(0, 3'b001, 32'h2002, 0, 32'hFFFF_80FF, 0, 1, 2, 1, "LH 2002");
    ls_access(0, 3'b100, 32'h2003, 0, 32'h0000_0080, 0, 1, 2, 1, "LBU 2003");
    ls_access(0, 3'b001, 32'h2000, 0, 32'h0000_7F01, 0, 1, 2, 1, "LH 2000");

    // Faults: no memory cycle, valid one cycle after grant edge
    ls_access(0, 3'b010, 32'h2002, 0, 0, 1, 0, 1, 0, "LW misaligned");
    ls_access(1, 3'b011, 32'h1000, 32'hFFFF_FFFF, 0, 1, 0, 1, 0, "SW f3=011");
    ls_access(0, 3'b001, 32'h2001, 0, 0, 1, 0, 1, 0, "LH misaligned");
    ls_access(1, 3'b100, 32'h1000, 32'hFFFF_FFFF, 0, 1, 0, 1, 0, "store f3=100");
    ls_access(0, 3'b011, 32'h2000, 0, 0, 1, 0, 1, 0, "load f3=011");
    ls_access(0, 3'b010, 32'h1000, 0, 32'hAB22_5566, 0, 1, 2, 1, "LW unchanged");

    // Fetch ignores low address bits
    fetch(32'h102, 32'h0050_0093, 2, 1, "fetch 102");

    // Watchdog
    ack_en = 1'b0;
    ls_access(0, 3'b010, 32'h2000, 0, 32'h0, 1, 1, 17, 16, "LS timeout");
    fetch(32'h100, 32'h0000_0013, 17, 16, "IF timeout");
    ack_en = 1'b1;
    ls_access(0, 3'b000, 32'h2001, 0, 32'h0000_007F, 0, 1, 2, 1, "LB after timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
